// File: rtl/prog_rom_loadable.sv
// prog_rom_loadable
// Loadable program memory for the 8-bit CPU. A program image is streamed in
// through a valid/ready loader port. The CPU then fetches words through a
// port with a registered one-cycle read. Addresses at or beyond the loaded
// program length read back as FILL.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   load_start            pulse: discard the current image and begin a new load
//   load_valid/load_data  loader word, with load_last marking the final word
//   load_ready            loader word accepted when load_valid & load_ready
//   load_done             one-cycle pulse when a load finishes
//   load_err              sticky: image overflowed DEPTH
//   prog_len              number of words in the current valid image
//   rd_ready              fetch port accepts requests (IDLE only)
//   rd_req/rd_addr        fetch request and address
//   rd_valid/rd_data      fetch result, one cycle after the request
module prog_rom_loadable #(
  parameter int                 DATA_W = 8,
  parameter int                 ADDR_W = 8,
  parameter int                 DEPTH  = 256,
  parameter logic [DATA_W-1:0]  FILL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_len,
  output logic              rd_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              final_word;
  logic              rd_fire;
  logic              rd_in_range;

  assign accept      = load_ready & load_valid;
  // A load ends either on the tagged last word or when the array is full.
  assign final_word  = load_last | (wr_ptr == LAST_PTR);
  assign rd_fire     = rd_req & rd_ready;
  // prog_len never exceeds DEPTH, but the DEPTH bound also keeps the array
  // index below from ever being used out of range.
  assign rd_in_range = ({1'b0, rd_addr} < prog_len) && ({1'b0, rd_addr} < DEPTH_L);

  // State register for the loader FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. A load_start while loading restarts
  // the image and blocks that cycle's loader word, so load_ready drops.
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    rd_ready   = 1'b0;
    case (state)
      IDLE: begin
        rd_ready = 1'b1;
        if (load_start) next_state = LOAD;
      end
      LOAD: begin
        if (!load_start) begin
          load_ready = 1'b1;
          if (load_valid && final_word) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Loader bookkeeping and the registered fetch path. The image length only
  // becomes visible once the load completes, so fetches during or after an
  // aborted load see FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      prog_len  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= FILL;
    end else begin
      load_done <= 1'b0;
      rd_valid  <= rd_fire;
      if (load_start) begin
        wr_ptr   <= '0;
        prog_len <= '0;
        load_err <= 1'b0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (final_word) begin
          load_done <= 1'b1;
          prog_len  <= {1'b0, wr_ptr} + 1'b1;
          // Reaching the end of the array without a last tag means words
          // were dropped.
          if (!load_last) load_err <= 1'b1;
        end
      end
      if (rd_fire) begin
        rd_data <= rd_in_range ? mem[rd_addr[IDX_W-1:0]] : FILL;
      end
    end
  end

  // Storage array; deliberately not reset since prog_len masks stale words.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[IDX_W-1:0]] <= load_data;
    end
  end

endmodule

// File: doc/prog_rom_loadable.md
Name: prog_rom_loadable

Overview:
Parametrised, synchronous program memory for the 8-bit CPU, replacing fixed case-statement ROMs. The program image is streamed in after reset through a valid/ready loader port, so the same RTL serves every assembled program. The CPU fetch port has a registered one-cycle read. Words at or beyond the loaded program length read back as a fill value.

Parameters:
DATA_W, 8, width of one program word
ADDR_W, 8, fetch/loader address width
DEPTH, 256, number of storage words; must satisfy 1 <= DEPTH <= 2**ADDR_W
FILL, 0, value returned for unloaded or out-of-range addresses (DATA_W bits)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: begin a new image load (discards current image)
load_valid  in  1  loader word present
load_data  in  DATA_W  loader word
load_last  in  1  qualifies final word of image (sampled with load_valid)
load_ready  out  1  loader word accepted this cycle when load_valid & load_ready
load_done  out  1  one-cycle pulse: load finished
load_err  out  1  sticky: image overflowed DEPTH; cleared by next load_start or reset
prog_len  out  ADDR_W+1  number of words in the current valid image
rd_ready  out  1  fetch port accepts requests (high only in IDLE)
rd_req  in  1  fetch request
rd_addr  in  ADDR_W  fetch address
rd_valid  out  1  fetch data valid
rd_data  out  DATA_W  fetch data

Behaviour:
- Reset (async assert, sync release): state=IDLE, prog_len=0, wr_ptr=0, load_ready=0, load_done=0, load_err=0, rd_valid=0, rd_data=FILL, rd_ready=1. Storage array is not reset; prog_len=0 masks it.
- States: IDLE, LOAD.
- IDLE: rd_ready=1, load_ready=0. load_start -> LOAD, wr_ptr=0, prog_len=0, load_err=0.
- LOAD: rd_ready=0, load_ready=1. On accept: mem[wr_ptr]=load_data, wr_ptr++.
  - Accept with load_last=1 -> IDLE next cycle, prog_len=wr_ptr+1, load_done pulse.
  - Accept of word at wr_ptr=DEPTH-1 without load_last -> IDLE, prog_len=DEPTH, load_err=1, load_done pulse; later words are not accepted (load_ready=0 in IDLE).
  - load_start in LOAD: restart: wr_ptr=0, prog_len stays 0, load_err=0, same-cycle load_valid word ignored (no write, not accepted: load_ready=0 that cycle).
  - load_start in IDLE with load_valid the same cycle: word ignored.
- Fetch: rd_req & rd_ready in cycle N -> rd_valid=1 in N+1, rd_data = mem[rd_addr] if rd_addr < prog_len, else FILL. Back-to-back requests give one result per cycle. No request -> rd_valid=0, rd_data holds last value.
- rd_req while rd_ready=0 is ignored (rd_valid=0 next cycle).
- Comparison rd_addr < prog_len is unsigned, ADDR_W+1 wide; addresses >= DEPTH always return FILL.
- load_done and a fetch cannot collide: fetch accepted only from the cycle after return to IDLE.
- Reset mid-load: image discarded (prog_len=0), all fetches return FILL until a new load completes.
- Throughput: one loader word per cycle; load of L words takes L accept cycles plus 1 cycle to return to IDLE.

Test Plan:
- After reset, fetch addr 0x00, 0x05, 0xFF -> rd_valid next cycle, rd_data=0x00 each; prog_len=0.
- Load 22 words 0x30,0x86,0x31,0x86,...,0x39,0x86,0x00,0xC4 (last on 0xC4) -> load_done one pulse, prog_len=22; fetch 0x00=0x30, 0x01=0x86, 0x15=0xC4, 0x16=0x00.
- Back-to-back fetches 0x00..0x03 on consecutive cycles -> rd_valid high 4 cycles, data 0x30,0x86,0x31,0x86 one cycle delayed.
- DEPTH=4: stream 6 words, no load_last -> 4 accepted, load_err=1, prog_len=4, load_ready low afterwards; fetch 0x04 -> 0x00.
- load_start after 3 words, then 2 words 0xAA,0xBB(last) -> prog_len=2, fetch 0x02 -> FILL; rd_req during load -> no rd_valid.
- Assert rst_n=0 mid-load for one cycle -> all outputs at reset values immediately, fetch 0x00 -> FILL.
